// File: rtl/tipi_pkg.sv
// Shared types and constants for the TIPI Raspberry Pi serial link.
package tipi_pkg;

  localparam int TIPI_BYTE_W = 8;

  // Channel select values carried on r_cd and held in cd_sel.
  localparam logic CH_DATA = 1'b0;
  localparam logic CH_CTRL = 1'b1;

  // Transaction FSM: wait for r_le, shift eight bits, wait for r_le to drop.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FULL  = 2'd2
  } link_state_e;

endpackage

// File: rtl/tipi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, followed by a single
// edge-detect flop that yields one-clk rise/fall pulses.
module tipi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchronizer chain plus the previous-level flop used for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the old value of
      // its neighbour, which is what makes this a chain of flops, not a wire.
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/tipi_rpi_link.sv
// Byte-wide serial link between the TI-side latches and a Raspberry Pi master.
// The RPi frames a transfer with r_le, clocks eight bits with r_clk, and the
// byte it shifted in is committed to rd_q or rc_q when r_le drops.
module tipi_rpi_link
  import tipi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [TIPI_BYTE_W-1:0] tc_data,
  input  logic [TIPI_BYTE_W-1:0] tc_ctrl,
  input  logic                   r_clk,
  input  logic                   r_le,
  input  logic                   r_cd,
  input  logic                   r_dout,
  output logic                   r_din,
  output logic [TIPI_BYTE_W-1:0] rd_q,
  output logic [TIPI_BYTE_W-1:0] rc_q,
  output logic                   rd_stb,
  output logic                   rc_stb,
  output logic                   xfer_err
);

  // Synchronized views of the RPi pins.
  logic clk_rise, le_rise, le_fall, cd_s, dout_s;
  logic unused_clk_lvl, unused_clk_fall, unused_le_lvl;
  logic unused_cd_rise, unused_cd_fall, unused_dout_rise, unused_dout_fall;

  tipi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(clk), .rst(rst), .async_in(r_clk),
    .level(unused_clk_lvl), .rise(clk_rise), .fall(unused_clk_fall)
  );
  tipi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_le (
    .clk(clk), .rst(rst), .async_in(r_le),
    .level(unused_le_lvl), .rise(le_rise), .fall(le_fall)
  );
  tipi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cd (
    .clk(clk), .rst(rst), .async_in(r_cd),
    .level(cd_s), .rise(unused_cd_rise), .fall(unused_cd_fall)
  );
  tipi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dout (
    .clk(clk), .rst(rst), .async_in(r_dout),
    .level(dout_s), .rise(unused_dout_rise), .fall(unused_dout_fall)
  );

  // After reset the synchronizers refill from zero, so an r_le already high
  // would look like a fresh rise; arm only once that artefact has passed.
  logic [SYNC_STAGES:0] warm_q;
  logic                 armed;

  // Warm-up shift register that fills with ones after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) warm_q <= '0;
    else     warm_q <= {warm_q[SYNC_STAGES-1:0], 1'b1};
  end

  assign armed = warm_q[SYNC_STAGES];

  link_state_e            state_q, state_n;
  logic [TIPI_BYTE_W-1:0] shreg_q, shreg_n;
  logic [3:0]             cnt_q, cnt_n;
  logic                   cd_q, cd_n;
  logic [TIPI_BYTE_W-1:0] rd_n, rc_n;
  logic                   rd_stb_n, rc_stb_n, err_n;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the committed bytes are ordinary registers, not a memory, so they
      // are reset along with the control state and read as 0 after reset.
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      cd_q     <= CH_DATA;
      rd_q     <= '0;
      rc_q     <= '0;
      rd_stb   <= 1'b0;
      rc_stb   <= 1'b0;
      xfer_err <= 1'b0;
    end else begin
      state_q  <= state_n;
      shreg_q  <= shreg_n;
      cnt_q    <= cnt_n;
      cd_q     <= cd_n;
      rd_q     <= rd_n;
      rc_q     <= rc_n;
      rd_stb   <= rd_stb_n;
      rc_stb   <= rc_stb_n;
      xfer_err <= err_n;
    end
  end

  // Next-state logic; an r_le fall always wins over a coincident r_clk rise.
  always_comb begin
    // NOTE: every signal gets a hold/default value first so no path through
    // the case statement leaves one unassigned and infers a latch.
    state_n  = state_q;
    shreg_n  = shreg_q;
    cnt_n    = cnt_q;
    cd_n     = cd_q;
    rd_n     = rd_q;
    rc_n     = rc_q;
    rd_stb_n = 1'b0;
    rc_stb_n = 1'b0;
    err_n    = xfer_err;
    case (state_q)
      ST_IDLE: begin
        if (le_rise && armed) begin
          cd_n    = cd_s;
          shreg_n = (cd_s == CH_CTRL) ? tc_ctrl : tc_data;
          cnt_n   = '0;
          state_n = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (le_fall) begin
          err_n   = 1'b1;
          state_n = ST_IDLE;
        end else if (clk_rise) begin
          shreg_n = {shreg_q[TIPI_BYTE_W-2:0], dout_s};
          cnt_n   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) state_n = ST_FULL;
        end
      end
      ST_FULL: begin
        if (le_fall) begin
          if (cd_q == CH_CTRL) begin
            rc_n     = shreg_q;
            rc_stb_n = 1'b1;
          end else begin
            rd_n     = shreg_q;
            rd_stb_n = 1'b1;
          end
          err_n   = 1'b0;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // MSB of the shift register drives the RPi, held low while idle.
  assign r_din = (state_q != ST_IDLE) & shreg_q[TIPI_BYTE_W-1];

endmodule

// File: tb/tb_tipi_rpi_link.sv
// Self-checking bench for tipi_rpi_link: directed scenarios plus randomized
// transfers, with committed bytes checked by a strobe-driven scoreboard.
module tb_tipi_rpi_link;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tc_data, tc_ctrl;
  logic       r_clk, r_le, r_cd, r_dout;
  logic       r_din;
  logic [7:0] rd_q, rc_q;
  logic       rd_stb, rc_stb, xfer_err;

  tipi_rpi_link #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .tc_data(tc_data), .tc_ctrl(tc_ctrl),
    .r_clk(r_clk), .r_le(r_le), .r_cd(r_cd), .r_dout(r_dout),
    .r_din(r_din), .rd_q(rd_q), .rc_q(rc_q),
    .rd_stb(rd_stb), .rc_stb(rc_stb), .xfer_err(xfer_err)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic       ch;
    logic [7:0] val;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] exp_rd = 8'h00;
  logic [7:0] exp_rc = 8'h00;
  logic       exp_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every strobe must match the oldest expected commit.
  always @(negedge clk) begin
    if (!rst && (rd_stb || rc_stb)) begin
      check("stb_onehot", 32'(rd_stb & rc_stb), 0);
      check("stb_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("stb_channel", 32'(rc_stb), 32'(e.ch));
        check("stb_value", 32'(e.ch ? rc_q : rd_q), 32'(e.val));
      end
    end
  end

  task automatic check_regs(input string tag);
    check({tag, "_rd_q"}, 32'(rd_q), 32'(exp_rd));
    check({tag, "_rc_q"}, 32'(rc_q), 32'(exp_rc));
    check({tag, "_xfer_err"}, 32'(xfer_err), 32'(exp_err));
    check({tag, "_r_din_idle"}, 32'(r_din), 0);
  endtask

  task automatic clk_pulse(input logic bit_val);
    r_dout = bit_val;
    r_clk  = 1'b1;
    wait_clk(5);
    r_clk  = 1'b0;
    wait_clk(5);
  endtask

  // One RPi transaction. The model: byte and channel are fixed at r_le rise,
  // the first eight clocked bits form the received byte, and the transfer
  // commits only if at least eight bits arrived before r_le fell.
  task automatic run_xfer(input logic ch, input logic [7:0] tcd, input logic [7:0] tcc,
                          input logic [7:0] rx, input int nbits,
                          input bit tog, input bit chg, input bit race);
    logic [7:0] loaded;
    tc_data = tcd;
    tc_ctrl = tcc;
    r_cd    = ch;
    r_dout  = 1'b0;
    wait_clk(5);
    loaded = ch ? tcc : tcd;
    r_le   = 1'b1;
    wait_clk(5);
    for (int i = 0; i < nbits; i++) begin
      if (i < 8) check("r_din_bit", 32'(r_din), 32'(loaded[7-i]));
      if (tog && i == 2) r_cd = ~r_cd;
      if (chg && i == 1) begin
        tc_data = 8'($urandom);
        tc_ctrl = 8'($urandom);
      end
      clk_pulse(i < 8 ? rx[7-i] : 1'($urandom_range(0, 1)));
    end
    if (nbits >= 8) begin
      check("r_din_full", 32'(r_din), 32'(rx[7]));
      exp_q.push_back('{ch: ch, val: rx});
      if (ch) exp_rc = rx;
      else    exp_rd = rx;
      exp_err = 1'b0;
    end else begin
      exp_err = 1'b1;
    end
    if (race) r_clk = 1'b1;
    r_le = 1'b0;
    wait_clk(6);
    r_clk = 1'b0;
    wait_clk(4);
    check_regs("post_xfer");
  endtask

  initial begin
    rst     = 1'b1;
    tc_data = 8'h00;
    tc_ctrl = 8'h00;
    r_clk   = 1'b0;
    r_le    = 1'b0;
    r_cd    = 1'b0;
    r_dout  = 1'b0;
    wait_clk(3);
    check("reset_stb", 32'({rd_stb, rc_stb}), 0);
    check_regs("reset");
    rst = 1'b0;
    wait_clk(5);

    // Data round trip, control channel.
    run_xfer(1'b0, 8'hA5, 8'h00, 8'h3C, 8, 1'b0, 1'b0, 1'b0);
    run_xfer(1'b1, 8'h00, 8'hF1, 8'h81, 8, 1'b0, 1'b0, 1'b0);
    // Abort after 5 bits, then a clean transfer clears the error.
    run_xfer(1'b0, 8'h5A, 8'h77, 8'hEE, 5, 1'b0, 1'b0, 1'b0);
    run_xfer(1'b0, 8'h12, 8'h34, 8'h96, 8, 1'b0, 1'b0, 1'b0);
    // Extra clocks with r_cd toggled mid-transaction, both start channels.
    run_xfer(1'b1, 8'hC3, 8'h69, 8'h4B, 11, 1'b1, 1'b1, 1'b0);
    run_xfer(1'b0, 8'h0F, 8'hF0, 8'hD2, 11, 1'b1, 1'b1, 1'b0);
    // r_le fall coincident with the 8th r_clk rise: the fall wins, abort.
    run_xfer(1'b1, 8'h11, 8'h22, 8'h99, 7, 1'b0, 1'b0, 1'b1);
    // Zero-bit abort.
    run_xfer(1'b0, 8'h33, 8'h44, 8'h55, 0, 1'b0, 1'b0, 1'b0);

    // Reset after 3 bits with r_le held high.
    tc_data = 8'hB7;
    r_cd    = 1'b0;
    wait_clk(5);
    r_le = 1'b1;
    wait_clk(5);
    for (int i = 0; i < 3; i++) clk_pulse(1'b1);
    rst = 1'b1;
    exp_rd  = 8'h00;
    exp_rc  = 8'h00;
    exp_err = 1'b0;
    wait_clk(2);
    check("rst_mid_stb", 32'({rd_stb, rc_stb}), 0);
    check_regs("rst_mid");
    rst = 1'b0;
    wait_clk(10);
    for (int i = 0; i < 8; i++) begin
      clk_pulse(1'($urandom_range(0, 1)));
      check("rst_release_r_din", 32'(r_din), 0);
    end
    r_le = 1'b0;
    wait_clk(10);
    check_regs("rst_release");
    run_xfer(1'b1, 8'h00, 8'h6D, 8'hA0, 8, 1'b0, 1'b0, 1'b0);

    // Randomized transfers.
    for (int t = 0; t < 40; t++) begin
      int nb;
      nb = (t % 3 == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(8, 11));
      run_xfer(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom), nb,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    wait_clk(10);
    check("sb_drain", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
